// File: rtl/rom_256x32bit.sv
// Fixed-content instruction ROM for the fetch stage.
// One-cycle registered read; maps onto block ROM.
module rom_256x32bit #(
    parameter int                WIDTH    = 32,
    parameter int                DEPTH    = 256,
    parameter int                ADDR_W   = 8,
    parameter logic [WIDTH-1:0]  NOP_WORD = WIDTH'(32'h0000_0013)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    output logic [WIDTH-1:0]  data
);

    logic [WIDTH-1:0] rom [DEPTH];
    logic [WIDTH-1:0] data_q = '0;

    // Smoke-test program at the bottom, NOP fill everywhere else
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rom[i] = NOP_WORD;
        end
        rom[0] = WIDTH'(32'h0050_0093);
        rom[1] = WIDTH'(32'h00A0_0113);
        rom[2] = WIDTH'(32'h0020_81B3);
        rom[3] = WIDTH'(32'h4011_0233);
        rom[4] = WIDTH'(32'h0030_2023);
        rom[5] = WIDTH'(32'h0000_2283);
        rom[6] = WIDTH'(32'h0032_8463);
        rom[7] = WIDTH'(32'h0010_0313);
        rom[8] = WIDTH'(32'h0000_006F);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= rom[addr];
        end
    end

    assign data = data_q;

endmodule

// File: tb/tb_rom_256x32bit.sv
// Directed self-checking bench for the instruction ROM.
// Each task drives one scenario and checks data inline.
module tb_rom_256x32bit;

    logic        clk;
    logic        rst;
    logic [7:0]  addr;
    logic [31:0] data;

    int checks = 0;
    int fails  = 0;

    rom_256x32bit dut (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .data (data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] exp_word(input logic [7:0] a);
        case (a)
            8'h00:   return 32'h0050_0093;
            8'h01:   return 32'h00A0_0113;
            8'h02:   return 32'h0020_81B3;
            8'h03:   return 32'h4011_0233;
            8'h04:   return 32'h0030_2023;
            8'h05:   return 32'h0000_2283;
            8'h06:   return 32'h0032_8463;
            8'h07:   return 32'h0010_0313;
            8'h08:   return 32'h0000_006F;
            default: return 32'h0000_0013;
        endcase
    endfunction

    // Present inputs, take one rising edge, settle past it.
    task automatic step(input logic [7:0] a, input logic r);
        addr = a;
        rst  = r;
        @(posedge clk);
        #1;
    endtask

    task automatic test_powerup;
        #1;
        checks++;
        if (data !== 32'h0) begin
            fails++;
            $display("FAIL powerup: data=%h expected=%h", data, 32'h0);
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 2; i++) begin
            step(8'h01, 1'b1);
            checks++;
            if (data !== 32'h0) begin
                fails++;
                $display("FAIL reset_hold%0d: data=%h expected=%h",
                         i, data, 32'h0);
            end
        end
        step(8'h01, 1'b0);
        checks++;
        if (data !== 32'h00A0_0113) begin
            fails++;
            $display("FAIL reset_release: data=%h expected=%h",
                     data, 32'h00A0_0113);
        end
    endtask

    task automatic test_sequential;
        logic [31:0] exp [5];
        exp[0] = 32'h0050_0093;
        exp[1] = 32'h00A0_0113;
        exp[2] = 32'h0020_81B3;
        exp[3] = 32'h4011_0233;
        exp[4] = 32'h0030_2023;
        for (int i = 0; i < 5; i++) begin
            step(8'(i), 1'b0);
            checks++;
            if (data !== exp[i]) begin
                fails++;
                $display("FAIL seq_addr%0d: data=%h expected=%h",
                         i, data, exp[i]);
            end
        end
    endtask

    task automatic test_latency;
        step(8'h02, 1'b0);
        addr = 8'h07;
        #3;
        checks++;
        if (data !== 32'h0020_81B3) begin
            fails++;
            $display("FAIL latency_hold: data=%h expected=%h",
                     data, 32'h0020_81B3);
        end
        for (int i = 0; i < 3; i++) begin
            step(8'h06, 1'b0);
            checks++;
            if (data !== 32'h0032_8463) begin
                fails++;
                $display("FAIL latency_stable%0d: data=%h expected=%h",
                         i, data, 32'h0032_8463);
            end
        end
    endtask

    task automatic test_fill;
        logic [7:0] a [4];
        logic [31:0] e [4];
        a[0] = 8'h09; e[0] = 32'h0000_0013;
        a[1] = 8'h80; e[1] = 32'h0000_0013;
        a[2] = 8'hFF; e[2] = 32'h0000_0013;
        a[3] = 8'h08; e[3] = 32'h0000_006F;
        for (int i = 0; i < 4; i++) begin
            step(a[i], 1'b0);
            checks++;
            if (data !== e[i]) begin
                fails++;
                $display("FAIL fill_%h: data=%h expected=%h",
                         a[i], data, e[i]);
            end
        end
    endtask

    task automatic test_mid_reset;
        step(8'h05, 1'b0);
        checks++;
        if (data !== 32'h0000_2283) begin
            fails++;
            $display("FAIL midrst_pre: data=%h expected=%h",
                     data, 32'h0000_2283);
        end
        step(8'h06, 1'b1);
        checks++;
        if (data !== 32'h0) begin
            fails++;
            $display("FAIL midrst_zero: data=%h expected=%h",
                     data, 32'h0);
        end
        step(8'h07, 1'b0);
        checks++;
        if (data !== 32'h0010_0313) begin
            fails++;
            $display("FAIL midrst_post: data=%h expected=%h",
                     data, 32'h0010_0313);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 256; i++) begin
            step(8'(i), 1'b0);
            checks++;
            if (data !== exp_word(8'(i))) begin
                fails++;
                $display("FAIL sweep_%h: data=%h expected=%h",
                         8'(i), data, exp_word(8'(i)));
            end
        end
    endtask

    initial begin
        rst  = 1'b0;
        addr = 8'h00;
        test_powerup();
        test_reset();
        test_sequential();
        test_latency();
        test_fill();
        test_mid_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/rom_256x32bit.md
Name: rom_256x32bit

Overview:
- Read-only instruction memory for the RISC-V core: 256 words x 32 bit, byte-free word addressing, 8-bit address.
- Contents are fixed at elaboration: a short RV32I smoke-test program at words 0..8; every other word is the canonical NOP.
- Synchronous read with a registered output, one clock of latency, so it maps onto block ROM. Sits between the PC/fetch stage and the decode stage.

Parameters:
- WIDTH, 32, data word width in bits; contents are defined for 32 only.
- DEPTH, 256, number of words; fixed, equals 2^ADDR_W.
- ADDR_W, 8, address width in bits.
- NOP_WORD, 32'h0000_0013, fill value for unprogrammed words (addi x0,x0,0).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- addr  input  ADDR_W (8)  word address, sampled on the rising edge.
- data  output  WIDTH (32)  registered read data.

Behaviour:
- Memory map, address -> word (hex):
  - 0x00 -> 00500093 (addi x1,x0,5)
  - 0x01 -> 00A00113 (addi x2,x0,10)
  - 0x02 -> 002081B3 (add x3,x1,x2)
  - 0x03 -> 40110233 (sub x4,x2,x1)
  - 0x04 -> 00302023 (sw x3,0(x0))
  - 0x05 -> 00002283 (lw x5,0(x0))
  - 0x06 -> 00328463 (beq x5,x3,+8)
  - 0x07 -> 00100313 (addi x6,x0,1)
  - 0x08 -> 0000006F (jal x0,0; self-loop)
  - 0x09..0xFF -> NOP_WORD
- Read timing: on each rising edge with rst=0, data <= mem[addr]. The new value is visible one cycle after addr is presented. data holds its value between edges and does not react combinationally to addr.
- Reset:
  - On a rising edge with rst=1, data <= 32'h0000_0000. Reset has priority over the read.
  - data stays 0 for every edge on which rst is high.
  - The first edge with rst=0 loads mem[addr].
- Reset mid-stream: asserting rst for one edge zeroes data for that cycle only. The read resumes on the next edge; no other state exists.
- Power-up: data is initialised to 0 before the first reset, so simulation never shows X.
- Address range: every 8-bit value is valid with no wrap logic. 0xFF returns NOP_WORD. X or Z bits on addr produce X on data in simulation only; no error signal.
- Back-to-back: a different addr on every cycle gives a different word on every cycle, with no stalls or bubbles.
- The block has no write port. Contents cannot change at run time.

Test Plan:
- Reset: hold rst=1 for 2 edges with addr=0x01 -> data=0x00000000 after each edge. Release rst -> next edge data=0x00A00113.
- Sequential fetch: rst=0, addr=0,1,2,3,4 on successive edges -> data one cycle later = 00500093, 00A00113, 002081B3, 40110233, 00302023.
- Latency: change addr between edges -> data unchanged until the next rising edge. Hold addr=0x06 for 3 edges -> data stable at 00328463.
- Fill region: addr=0x09, 0x80, 0xFF -> data=00000013 each. addr=0x08 -> 0000006F.
- Reset mid-stream: streaming addr=5,6,7 with rst=1 on the edge for 6 -> data 00002283, 00000000, 00100313.
- Exhaustive sweep: addr 0x00..0xFF -> every returned word matches the memory map above, 256 checks, zero mismatches.
